order_scheduler: RTL and testbench

Front-end controller for the 8-deep matching engine. It accepts price orders from N independent sources and arbitrates them round-robin into per-side FIFOs. It meters them into the engine's buy_price/sell_price inputs, exactly one order per side per issue tick, and drives neutral fillers (buy 0x00, sell 0xFF) on all other cycles. It also edge-detects the engine's level match_flag into one-shot trade events and keeps a trade counter.

---
 rtl/order_scheduler_if.sv | 14 +
 rtl/order_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_order_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/order_scheduler_if.sv
// Order-source handshake bundle: N_SRC sources offering (side, price) to the scheduler.
// Handshake: an order moves on a cycle where src_valid[i] & src_ready[i]; a source holds valid/side/price stable until then.
interface order_scheduler_if #(
  parameter int N_SRC   = 4,
  parameter int PRICE_W = 8
);
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_side;
  logic [N_SRC*PRICE_W-1:0] src_price;
  logic [N_SRC-1:0]         src_ready;

  modport master (output src_valid, output src_side, output src_price, input src_ready);
  modport slave  (input src_valid, input src_side, input src_price, output src_ready);
endinterface

// File: rtl/order_scheduler.sv
// Front-end for the matching engine: round-robin order intake into buy/sell FIFOs,
// one-per-tick metering onto the engine price inputs, and trade edge detection/counting.
module order_scheduler #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PRICE_W    = 8,
  parameter int FLUSH_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          halt,
  input  logic                          flush,
  input  logic                          issue_en,
  order_scheduler_if.slave              src,
  output logic [PRICE_W-1:0]            buy_price,
  output logic [PRICE_W-1:0]            sell_price,
  input  logic                          match_flag,
  input  logic [PRICE_W-1:0]            trade_price,
  output logic                          trade_valid,
  output logic [PRICE_W-1:0]            trade_price_q,
  output logic [15:0]                   trade_count,
  output logic [1:0]                    state,
  output logic [$clog2(FIFO_DEPTH):0]   buy_level,
  output logic [$clog2(FIFO_DEPTH):0]   sell_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t            st;
  logic [FW-1:0]     flush_cnt;
  logic [PW-1:0]     rr_ptr;

  logic [PRICE_W-1:0] buy_mem  [FIFO_DEPTH];
  logic [PRICE_W-1:0] sell_mem [FIFO_DEPTH];
  logic [AW-1:0]      buy_rd, buy_wr, sell_rd, sell_wr;
  logic [LW-1:0]      buy_cnt, sell_cnt;

  logic               issue, pop_buy, pop_sell, push_buy, push_sell;
  logic               buy_ok, sell_ok, arb_on, arb_hit, flush_done;
  logic [N_SRC-1:0]   grant;
  logic [PW-1:0]      grant_idx;
  logic [PRICE_W-1:0] push_price;
  logic               match_q, match_rise;

  assign state      = st;
  assign buy_level  = buy_cnt;
  assign sell_level = sell_cnt;

  assign issue      = (st == ST_RUN) && issue_en;
  assign pop_buy    = issue && (buy_cnt != '0);
  assign pop_sell   = issue && (sell_cnt != '0);
  // A full FIFO still takes an order when its head leaves in the same cycle.
  assign buy_ok     = (buy_cnt != LW'(FIFO_DEPTH)) || pop_buy;
  assign sell_ok    = (sell_cnt != LW'(FIFO_DEPTH)) || pop_sell;
  assign arb_on     = (st == ST_RUN) || (st == ST_HOLD);
  assign flush_done = (st == ST_FLUSH) && issue_en && (flush_cnt == FW'(FLUSH_LEN - 1));

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    arb_hit   = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % N_SRC;
      if (!arb_hit && arb_on && src.src_valid[idx] &&
          (src.src_side[idx] ? buy_ok : sell_ok)) begin
        arb_hit    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  assign src.src_ready = grant;
  assign push_price    = src.src_price[int'(grant_idx)*PRICE_W +: PRICE_W];
  assign push_buy      = arb_hit && src.src_side[grant_idx];
  assign push_sell     = arb_hit && !src.src_side[grant_idx];

  always_ff @(posedge clk) begin
    if (push_buy)  buy_mem[buy_wr]   <= push_price;
    if (push_sell) sell_mem[sell_wr] <= push_price;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buy_rd   <= '0;
      buy_wr   <= '0;
      buy_cnt  <= '0;
      sell_rd  <= '0;
      sell_wr  <= '0;
      sell_cnt <= '0;
    end else if (flush_done) begin
      buy_rd   <= '0;
      buy_wr   <= '0;
      buy_cnt  <= '0;
      sell_rd  <= '0;
      sell_wr  <= '0;
      sell_cnt <= '0;
    end else begin
      if (push_buy)  buy_wr  <= buy_wr + 1'b1;
      if (pop_buy)   buy_rd  <= buy_rd + 1'b1;
      if (push_sell) sell_wr <= sell_wr + 1'b1;
      if (pop_sell)  sell_rd <= sell_rd + 1'b1;
      case ({push_buy, pop_buy})
        2'b10:   buy_cnt <= buy_cnt + 1'b1;
        2'b01:   buy_cnt <= buy_cnt - 1'b1;
        default: buy_cnt <= buy_cnt;
      endcase
      case ({push_sell, pop_sell})
        2'b10:   sell_cnt <= sell_cnt + 1'b1;
        2'b01:   sell_cnt <= sell_cnt - 1'b1;
        default: sell_cnt <= sell_cnt;
      endcase
    end
  end

  // Engine inputs carry a real price for exactly one cycle per issue; neutral otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= ST_IDLE;
      flush_cnt  <= '0;
      rr_ptr     <= '0;
      buy_price  <= '0;
      sell_price <= '1;
    end else begin
      buy_price  <= pop_buy  ? buy_mem[buy_rd]   : '0;
      sell_price <= pop_sell ? sell_mem[sell_rd] : '1;
      if (arb_hit) rr_ptr <= (grant_idx == PW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
      case (st)
        ST_IDLE: begin
          flush_cnt <= '0;
          if (flush)                st <= ST_FLUSH;
          else if (enable && !halt) st <= ST_RUN;
        end
        ST_RUN: begin
          flush_cnt <= '0;
          if (flush)        st <= ST_FLUSH;
          else if (halt)    st <= ST_HOLD;
          else if (!enable) st <= ST_IDLE;
        end
        ST_HOLD: begin
          flush_cnt <= '0;
          if (flush)     st <= ST_FLUSH;
          else if (!halt) st <= enable ? ST_RUN : ST_IDLE;
        end
        ST_FLUSH: begin
          if (issue_en) begin
            if (flush_done) begin
              st        <= ST_IDLE;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign match_rise = match_flag && !match_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q       <= 1'b0;
      trade_valid   <= 1'b0;
      trade_price_q <= '0;
      trade_count   <= '0;
    end else begin
      match_q     <= match_flag;
      trade_valid <= match_rise;
      if (match_rise) begin
        trade_price_q <= trade_price;
        if (trade_count != 16'hFFFF) trade_count <= trade_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_order_scheduler.sv
// Directed bench for order_scheduler with a price scoreboard per engine side.
module tb_order_scheduler;
  localparam int N = 4;

  logic       clk, reset_n, enable, halt, flush, issue_en;
  logic       match_flag;
  logic [7:0] trade_price;
  logic [7:0] buy_price, sell_price, trade_price_q;
  logic       trade_valid;
  logic [15:0] trade_count;
  logic [1:0] state;
  logic [2:0] buy_level, sell_level;

  logic [7:0] exp_buy_q[$];
  logic [7:0] exp_sell_q[$];
  int checks = 0;
  int errors = 0;
  int tv_pulses = 0;

  order_scheduler_if #(.N_SRC(N), .PRICE_W(8)) sif ();

  order_scheduler #(.N_SRC(N), .FIFO_DEPTH(4), .PRICE_W(8), .FLUSH_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .halt(halt), .flush(flush),
    .issue_en(issue_en), .src(sif.slave), .buy_price(buy_price), .sell_price(sell_price),
    .match_flag(match_flag), .trade_price(trade_price), .trade_valid(trade_valid),
    .trade_price_q(trade_price_q), .trade_count(trade_count), .state(state),
    .buy_level(buy_level), .sell_level(sell_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src(input int i, input logic side, input logic [7:0] price);
    sif.src_valid[i]          = 1'b1;
    sif.src_side[i]           = side;
    sif.src_price[i*8 +: 8]   = price;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge after scoring outputs.
  task automatic tick();
    logic [N-1:0] acc;
    #1;
    acc = sif.src_valid & sif.src_ready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (sif.src_side[i]) exp_buy_q.push_back(sif.src_price[i*8 +: 8]);
        else                 exp_sell_q.push_back(sif.src_price[i*8 +: 8]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (trade_valid) tv_pulses++;
    if (buy_price !== 8'h00) begin
      if (exp_buy_q.size() == 0) chk("buy_extra", buy_price, 8'h00);
      else                       chk("buy_issue", buy_price, exp_buy_q.pop_front());
    end
    if (sell_price !== 8'hFF) begin
      if (exp_sell_q.size() == 0) chk("sell_extra", sell_price, 8'hFF);
      else                        chk("sell_issue", sell_price, exp_sell_q.pop_front());
    end
    sif.src_valid = sif.src_valid & ~acc;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; halt = 1'b0; flush = 1'b0; issue_en = 1'b0;
    match_flag = 1'b0; trade_price = 8'h00;
    sif.src_valid = '0; sif.src_side = '0; sif.src_price = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_buy", buy_price, 8'h00);
    chk("rst_sell", sell_price, 8'hFF);
    chk("rst_ready", sif.src_ready, 0);
    chk("rst_count", trade_count, 0);
    chk("rst_blvl", buy_level, 0);
    reset_n = 1'b1;

    // Idle run with no orders
    enable = 1'b1;
    tick();
    chk("run_state", state, 1);
    issue_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_buy", buy_price, 8'h00);
      chk("idle_sell", sell_price, 8'hFF);
      chk("idle_ready", sif.src_ready, 0);
    end
    chk("idle_count", trade_count, 0);
    issue_en = 1'b0;

    // Four sources at once: round-robin grants 0,1,2,3
    drive_src(0, 1'b1, 8'h40);
    drive_src(1, 1'b0, 8'h50);
    drive_src(2, 1'b1, 8'h60);
    drive_src(3, 1'b0, 8'h30);
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", sif.src_ready, 4'b0001 << k);
      tick();
    end
    chk("rr_blvl", buy_level, 2);
    chk("rr_slvl", sell_level, 2);

    // Issue both pairs, then neutral
    issue_en = 1'b1;
    tick();
    chk("iss1_buy", buy_price, 8'h40);
    chk("iss1_sell", sell_price, 8'h50);
    tick();
    chk("iss2_buy", buy_price, 8'h60);
    chk("iss2_sell", sell_price, 8'h30);
    issue_en = 1'b0;
    tick();
    chk("iss3_buy", buy_price, 8'h00);
    chk("iss3_sell", sell_price, 8'hFF);

    // Trade edge detection
    match_flag = 1'b1; trade_price = 8'h48;
    tick();
    trade_price = 8'h99;
    repeat (3) tick();
    match_flag = 1'b0;
    tick();
    chk("trade_pulses", tv_pulses, 1);
    chk("trade_cnt1", trade_count, 1);
    chk("trade_q1", trade_price_q, 8'h48);
    match_flag = 1'b1; trade_price = 8'h22;
    tick();
    match_flag = 1'b0;
    tick();
    chk("trade_pulses2", tv_pulses, 2);
    chk("trade_cnt2", trade_count, 2);
    chk("trade_q2", trade_price_q, 8'h22);

    // Fill buy FIFO, then back-pressure and same-cycle push/pop
    for (int k = 0; k < 4; k++) begin
      drive_src(0, 1'b1, 8'h10 + 8'(k));
      tick();
    end
    chk("full_blvl", buy_level, 4);
    drive_src(0, 1'b1, 8'h21);
    drive_src(1, 1'b0, 8'h71);
    #1 chk("full_sell_grant", sif.src_ready, 4'b0010);
    tick();
    #1 chk("full_no_grant", sif.src_ready, 4'b0000);
    issue_en = 1'b1;
    #1 chk("full_pop_grant", sif.src_ready, 4'b0001);
    tick();
    issue_en = 1'b0;
    chk("pp_buy", buy_price, 8'h10);
    chk("pp_blvl", buy_level, 4);
    chk("pp_slvl", sell_level, 0);

    // Halt: arbitration continues, issuing frozen
    halt = 1'b1;
    tick();
    chk("hold_state", state, 2);
    drive_src(2, 1'b0, 8'h55);
    issue_en = 1'b1;
    #1 chk("hold_grant", sif.src_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_buy", buy_price, 8'h00);
      chk("hold_sell", sell_price, 8'hFF);
    end
    chk("hold_blvl", buy_level, 4);
    chk("hold_slvl", sell_level, 1);
    halt = 1'b0; issue_en = 1'b0;
    tick();
    chk("resume_state", state, 1);
    issue_en = 1'b1;
    tick();
    chk("resume_buy1", buy_price, 8'h11);
    chk("resume_sell1", sell_price, 8'h55);
    tick();
    chk("resume_buy2", buy_price, 8'h12);
    issue_en = 1'b0;
    tick();
    chk("resume_blvl", buy_level, 2);
    chk("sell_drained", exp_sell_q.size(), 0);

    // Flush: 8 neutral issue ticks, then IDLE with empty FIFOs
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_state", state, 3);
    drive_src(0, 1'b1, 8'h77);
    #1 chk("flush_ready", sif.src_ready, 0);
    issue_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("flush_buy", buy_price, 8'h00);
      chk("flush_sell", sell_price, 8'hFF);
      if (k == 6) chk("flush_state7", state, 3);
    end
    chk("flush_idle", state, 0);
    chk("flush_blvl", buy_level, 0);
    chk("flush_slvl", sell_level, 0);
    sif.src_valid = '0;
    exp_buy_q.delete();
    exp_sell_q.delete();
    issue_en = 1'b0;

    // Reset in the middle of a flush
    tick();
    chk("rerun_state", state, 1);
    drive_src(1, 1'b1, 8'h33);
    #1 chk("rerun_grant", sif.src_ready, 4'b0010);
    tick();
    chk("rerun_blvl", buy_level, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_en = 1'b1;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_buy", buy_price, 8'h00);
    chk("mid_rst_sell", sell_price, 8'hFF);
    chk("mid_rst_blvl", buy_level, 0);
    chk("mid_rst_count", trade_count, 0);
    chk("mid_rst_tq", trade_price_q, 0);
    chk("mid_rst_tv", trade_valid, 0);
    chk("mid_rst_ready", sif.src_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_buy_q.delete();
    exp_sell_q.delete();
    issue_en = 1'b0;
    tick();
    chk("post_rst_state", state, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
